// File: rtl/present_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : present_pkg                                                |
// | Description : Shared PRESENT constants: the forward and inverse S-box    |
// |               tables packed as 16 nibbles (entry x at bits [4x+3:4x]),   |
// |               state/nibble widths, the layer FSM encoding and a nibble   |
// |               table lookup helper.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package present_pkg;

  localparam int STATE_W = 64;
  localparam int NIB_W   = 4;

  // Entry x of each table lives at bits [4x+3:4x]; written MSB (x=F) first.
  localparam logic [63:0] SBOX_INV = 64'hA970_364B_D21C_8FE5;
  localparam logic [63:0] SBOX_FWD = 64'h2174_8FE3_DA09_B65C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic logic [NIB_W-1:0] nib_lookup(input logic [63:0] tbl,
                                                  input logic [NIB_W-1:0] x);
    return tbl[{x, 2'b00} +: NIB_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/present_sbox_nibble.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : present_sbox_nibble                                        |
// | Description : Combinational 4-bit PRESENT S-box lookup.                  |
// |               x   : input nibble                                         |
// |               fwd : 1 selects forward S, 0 selects S^-1                  |
// |               y   : substituted nibble                                   |
// |               Macro PRESENT_FWD_SBOX_EN adds the forward table; without  |
// |               it the lookup is inverse-only and fwd has no effect.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module present_sbox_nibble
  import present_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic             fwd,
  output logic [NIB_W-1:0] y
);

`ifdef PRESENT_FWD_SBOX_EN
  assign y = fwd ? nib_lookup(SBOX_FWD, x) : nib_lookup(SBOX_INV, x);
`else
  // Direction input kept for a uniform port list; inverse-only build ignores it.
  logic w_fwd_unused;
  assign w_fwd_unused = fwd;
  assign y = nib_lookup(SBOX_INV, x);
`endif

endmodule
`default_nettype wire

// File: rtl/present_inv_sbox_layer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : present_inv_sbox_layer                                     |
// | Description : Serialized PRESENT inverse substitution layer. Applies     |
// |               S^-1 to all 16 nibbles of a 64-bit state, LANES nibbles    |
// |               per BUSY cycle, behind valid/ready handshakes.             |
// |   clk        : rising-edge clock                                         |
// |   rst_n      : asynchronous active-low reset                             |
// |   in_valid   : data_in valid          in_ready  : accepting (IDLE)       |
// |   data_in    : 64-bit input state     fwd       : direction (optional)   |
// |   out_valid  : result available       out_ready : consumer takes result  |
// |   data_out   : 64-bit result          busy      : substitution running   |
// |   Macro PRESENT_FWD_SBOX_EN adds the fwd port and the forward table.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module present_inv_sbox_layer
  import present_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] data_in,
`ifdef PRESENT_FWD_SBOX_EN
  input  logic               fwd,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] data_out,
  output logic               busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SUB_W = NIB_W * LANES;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STEPS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("present_inv_sbox_layer: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  fsm_t               r_fsm;
  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_fwd;
  logic [SUB_W-1:0]   w_sub;
  logic [STATE_W-1:0] w_next;

`ifdef PRESENT_FWD_SBOX_EN
  // Direction is latched at acceptance so it holds for the whole transaction.
  logic r_fwd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd <= 1'b0;
    end else if (r_fsm == IDLE && in_valid) begin
      r_fwd <= fwd;
    end
  end
  assign w_fwd = r_fwd;
`else
  assign w_fwd = 1'b0;
`endif

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      present_sbox_nibble u_nib (
        .x   (r_state[NIB_W*i +: NIB_W]),
        .fwd (w_fwd),
        .y   (w_sub[NIB_W*i +: NIB_W])
      );
    end
  endgenerate

  // Substituted nibbles re-enter at the top, so after STEPS rotations every
  // nibble is back at its original index.
  generate
    if (LANES == 16) begin : g_rot_full
      assign w_next = w_sub;
    end else begin : g_rot_part
      assign w_next = {w_sub, r_state[STATE_W-1:SUB_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= data_in;
            r_cnt   <= '0;
            r_fsm   <= BUSY;
          end
        end
        BUSY: begin
          r_state <= w_next;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_CNT_LAST) begin
            r_fsm <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_fsm <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_fsm == IDLE);
  assign busy      = (r_fsm == BUSY);
  assign out_valid = (r_fsm == DONE);
  assign data_out  = r_state;

endmodule
`default_nettype wire
